// File: rtl/axi_pkg.sv
// Shared AXI types for the request arbiter: channel structs, response codes,
// arbiter FSM states and a round-robin index helper.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axi_resp_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_DATA = 3'd4,
    WR_RESP = 3'd5
  } axi_arb_state_t;

  typedef struct packed {
    logic        awvalid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
  } axi_aw_t;

  typedef struct packed {
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
  } axi_w_t;

  typedef struct packed {
    logic        arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
  } axi_ar_t;

  typedef struct packed {
    axi_aw_t aw;
    axi_w_t  w;
    axi_ar_t ar;
  } axi_request_t;

  // Index following idx in a ring of n entries.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    if (idx + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/axi_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any_req
);

  localparam int IW = $clog2(N);

  int          pos_s;
  logic [IW-1:0] pos_idx_s;

  // Walk the ring from the far end back to ptr so the nearest request wins last.
  always_comb begin
    onehot    = '0;
    idx       = '0;
    pos_s     = 0;
    pos_idx_s = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos_s = int'(ptr) + i;
      if (pos_s >= N) begin
        pos_s = pos_s - N;
      end else begin
        pos_s = pos_s;
      end
      pos_idx_s = IW'(pos_s);
      if (req[pos_idx_s]) begin
        onehot            = '0;
        onehot[pos_idx_s] = 1'b1;
        idx               = pos_idx_s;
      end else begin
        idx = idx;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/axi_req_arbiter.sv
// Round-robin arbiter sharing one AXI master port among NUM_REQ requesters,
// one transaction in flight. Optional stall watchdog: define AXI_ARB_WDOG_EN.
module axi_req_arbiter
  import axi_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  axi_request_t               s_req [NUM_REQ],
  output logic [NUM_REQ-1:0]         s_awready,
  output logic [NUM_REQ-1:0]         s_wready,
  output logic [NUM_REQ-1:0]         s_arready,
  output logic [NUM_REQ-1:0]         s_rvalid,
  output logic [31:0]                s_rdata,
  output logic [1:0]                 s_rresp,
  output logic                       s_rlast,
  output logic [NUM_REQ-1:0]         s_bvalid,
  output logic [1:0]                 s_bresp,
  output axi_request_t               m_req,
  input  logic                       m_awready,
  input  logic                       m_wready,
  input  logic                       m_arready,
  input  logic                       m_rvalid,
  input  logic [31:0]                m_rdata,
  input  logic [1:0]                 m_rresp,
  input  logic                       m_rlast,
  output logic                       m_rready,
  input  logic                       m_bvalid,
  input  logic [1:0]                 m_bresp,
  output logic                       m_bready,
  output logic [$clog2(NUM_REQ)-1:0] grant,
  output logic                       busy,
  output logic                       wdog_err
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("axi_req_arbiter: NUM_REQ must be at least 2");
  end
  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("axi_req_arbiter: WDOG_CYCLES must be at least 1");
  end

  axi_arb_state_t state_r, state_nxt_s;
  logic [IW-1:0]  grant_r, grant_nxt_s;
  logic [IW-1:0]  rr_ptr_r, rr_ptr_nxt_s;

  logic [NUM_REQ-1:0] cand_s;
  logic [NUM_REQ-1:0] arv_s;
  logic [NUM_REQ-1:0] win_onehot_s;
  logic [IW-1:0]      win_idx_s;
  logic               any_req_s;
  logic               rd_pick_s;
  logic               done_s;

  logic ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s;

  // Requesters asking for either direction compete; reads are tracked separately.
  always_comb begin
    cand_s = '0;
    arv_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      arv_s[i]  = s_req[i].ar.arvalid;
      cand_s[i] = s_req[i].ar.arvalid | s_req[i].aw.awvalid;
    end
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (cand_s),
    .ptr     (rr_ptr_r),
    .onehot  (win_onehot_s),
    .idx     (win_idx_s),
    .any_req (any_req_s)
  );

  assign rd_pick_s = |(win_onehot_s & arv_s);

  assign ar_hs_s = (state_r == RD_ADDR) && s_req[grant_r].ar.arvalid && m_arready;
  assign r_hs_s  = (state_r == RD_DATA) && m_rvalid;
  assign aw_hs_s = (state_r == WR_ADDR) && s_req[grant_r].aw.awvalid && m_awready;
  assign w_hs_s  = (state_r == WR_DATA) && s_req[grant_r].w.wvalid && m_wready;
  assign b_hs_s  = (state_r == WR_RESP) && m_bvalid;

`ifdef AXI_ARB_WDOG_EN
  localparam int WCW = $clog2(WDOG_CYCLES + 1);

  logic [WCW-1:0] wdog_cnt_r;
  logic           wdog_err_r;
  logic           abort_s;
  logic           any_hs_s;

  assign any_hs_s = ar_hs_s | r_hs_s | aw_hs_s | w_hs_s | b_hs_s;
  assign abort_s  = (state_r != IDLE) && (wdog_cnt_r == WCW'(WDOG_CYCLES));
  assign wdog_err = wdog_err_r;

  // Stall counter and sticky abort flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_r <= '0;
      wdog_err_r <= 1'b0;
    end else begin
      if ((state_r == IDLE) || any_hs_s || abort_s) begin
        wdog_cnt_r <= '0;
      end else begin
        wdog_cnt_r <= wdog_cnt_r + WCW'(1);
      end
      if (abort_s) begin
        wdog_err_r <= 1'b1;
      end else begin
        wdog_err_r <= wdog_err_r;
      end
    end
  end
`else
  assign wdog_err = 1'b0;
`endif

  // Next state and channel routing; everything not owned by the state is muted.
  always_comb begin
    state_nxt_s  = state_r;
    grant_nxt_s  = grant_r;
    rr_ptr_nxt_s = rr_ptr_r;
    done_s       = 1'b0;
    m_req        = '0;
    m_rready     = 1'b0;
    m_bready     = 1'b0;
    s_awready    = '0;
    s_wready     = '0;
    s_arready    = '0;
    s_rvalid     = '0;
    s_bvalid     = '0;
    s_rdata      = m_rdata;
    s_rresp      = m_rresp;
    s_rlast      = m_rlast;
    s_bresp      = m_bresp;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          grant_nxt_s = win_idx_s;
          state_nxt_s = rd_pick_s ? RD_ADDR : WR_ADDR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD_ADDR: begin
        m_req.ar           = s_req[grant_r].ar;
        s_arready[grant_r] = m_arready;
        if (ar_hs_s) begin
          state_nxt_s = RD_DATA;
        end else begin
          state_nxt_s = RD_ADDR;
        end
      end
      RD_DATA: begin
        m_rready          = 1'b1;
        s_rvalid[grant_r] = m_rvalid;
        if (r_hs_s && m_rlast) begin
          done_s = 1'b1;
        end else begin
          done_s = 1'b0;
        end
      end
      WR_ADDR: begin
        m_req.aw           = s_req[grant_r].aw;
        s_awready[grant_r] = m_awready;
        if (aw_hs_s) begin
          state_nxt_s = WR_DATA;
        end else begin
          state_nxt_s = WR_ADDR;
        end
      end
      WR_DATA: begin
        m_req.w           = s_req[grant_r].w;
        s_wready[grant_r] = m_wready;
        if (w_hs_s && s_req[grant_r].w.wlast) begin
          state_nxt_s = WR_RESP;
        end else begin
          state_nxt_s = WR_DATA;
        end
      end
      WR_RESP: begin
        m_bready          = 1'b1;
        s_bvalid[grant_r] = m_bvalid;
        if (b_hs_s) begin
          done_s = 1'b1;
        end else begin
          done_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

`ifdef AXI_ARB_WDOG_EN
    // A stalled transaction is closed toward its requester with a synthetic SLVERR.
    if (abort_s) begin
      m_req     = '0;
      m_rready  = 1'b0;
      m_bready  = 1'b0;
      s_awready = '0;
      s_wready  = '0;
      s_arready = '0;
      s_rvalid  = '0;
      s_bvalid  = '0;
      if ((state_r == RD_ADDR) || (state_r == RD_DATA)) begin
        s_rvalid[grant_r] = 1'b1;
        s_rresp           = SLVERR;
        s_rlast           = 1'b1;
      end else begin
        s_bvalid[grant_r] = 1'b1;
        s_bresp           = SLVERR;
      end
      done_s = 1'b1;
    end else begin
      done_s = done_s;
    end
`endif

    if (done_s) begin
      state_nxt_s  = IDLE;
      rr_ptr_nxt_s = IW'(rr_next(int'(grant_r), NUM_REQ));
    end else begin
      rr_ptr_nxt_s = rr_ptr_nxt_s;
    end
  end

  // FSM, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      grant_r  <= '0;
      rr_ptr_r <= '0;
    end else begin
      state_r  <= state_nxt_s;
      grant_r  <= grant_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
    end
  end

  assign grant = grant_r;
  assign busy  = (state_r != IDLE);

endmodule
